// File: rtl/mem_pkg.sv
// Shared types and helpers for the byte-enabled dual-port RAM.
//   mem_state_t : clear-engine state (clear in progress / normal operation)
//   be_w()      : number of byte lanes for a given word width
//   be_merge()  : per-byte select between the stored byte and a new byte
package mem_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } mem_state_t;

    function automatic int be_w(input int data_w);
        return data_w / 8;
    endfunction

    // One byte lane of a byte-enabled write: take the new byte when enabled.
    function automatic logic [7:0] be_merge(input logic [7:0] old_byte,
                                            input logic [7:0] new_byte,
                                            input logic       be);
        return be ? new_byte : old_byte;
    endfunction

endpackage

// File: rtl/mem_clear_ctrl.sv
// Post-reset clear engine for mem_dp_be.
// Walks every address once after reset, asking the top level to write zero.
//   clk, rst   : clock, asynchronous active-high reset
//   clr_we     : top must write zero to clr_addr this cycle
//   clr_addr   : address being cleared
//   init_busy  : high while clearing; user ports are ignored meanwhile
module mem_clear_ctrl
    import mem_pkg::*;
#(
    parameter int ADDR_W     = 8,
    parameter int INIT_CLEAR = 1
) (
    input  logic              clk,
    input  logic              rst,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr,
    output logic              init_busy
);

    localparam int         DEPTH     = 2 ** ADDR_W;
    localparam mem_state_t RST_STATE = (INIT_CLEAR != 0) ? ST_CLEAR : ST_RUN;
    localparam logic [ADDR_W:0] CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0] CNT_LAST = DEPTH[ADDR_W:0];

    mem_state_t      state_q, state_d;
    // One extra bit so that "all words written" is a distinct count value.
    logic [ADDR_W:0] cnt_q, cnt_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == ST_CLEAR) begin
            cnt_d = cnt_q + CNT_ONE;
            if (cnt_d == CNT_LAST) begin
                state_d = ST_RUN;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RST_STATE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign clr_we    = (state_q == ST_CLEAR);
    assign clr_addr  = cnt_q[ADDR_W-1:0];
    assign init_busy = (state_q == ST_CLEAR);

endmodule

// File: rtl/mem_dp_be.sv
// Simple-dual-port synchronous RAM with byte-enabled writes, optional output
// register, selectable read-during-write behaviour and a post-reset clear.
//   clk, rst          : clock, asynchronous active-high reset (array not reset)
//   init_busy         : clear engine running; requests are dropped
//   wr_en/addr/data/be: write port, bytes with wr_be[i]=1 are updated
//   rd_en/addr        : read request
//   rd_data/rd_valid  : returned word and its one-cycle qualifier; rd_data
//                       holds its value between returned words
// Read latency is 1 + OUT_REG cycles, fully pipelined.
module mem_dp_be
    import mem_pkg::*;
#(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 32,
    parameter int OUT_REG    = 1,
    parameter int RDW_MODE   = 0,
    parameter int INIT_CLEAR = 1
) (
    input  logic                clk,
    input  logic                rst,
    output logic                init_busy,
    input  logic                wr_en,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic [DATA_W/8-1:0] wr_be,
    input  logic                rd_en,
    input  logic [ADDR_W-1:0]   rd_addr,
    output logic [DATA_W-1:0]   rd_data,
    output logic                rd_valid
);

    localparam int BE_W  = be_w(DATA_W);
    localparam int DEPTH = 2 ** ADDR_W;

    if (DATA_W % 8 != 0) begin : g_bad_width
        $error("mem_dp_be: DATA_W must be a multiple of 8");
    end

    // ------------------------------------------------------------------
    // Clear engine and write-port arbitration
    // ------------------------------------------------------------------
    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;

    mem_clear_ctrl #(
        .ADDR_W     (ADDR_W),
        .INIT_CLEAR (INIT_CLEAR)
    ) u_clear (
        .clk       (clk),
        .rst       (rst),
        .clr_we    (clr_we),
        .clr_addr  (clr_addr),
        .init_busy (init_busy)
    );

    logic              usr_we;
    logic              rd_fire;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [BE_W-1:0]   ram_be;

    always_comb begin
        usr_we    = wr_en & ~init_busy;
        rd_fire   = rd_en & ~init_busy;
        // Clear writes own the port while busy; user writes are dropped.
        ram_we    = clr_we | usr_we;
        ram_addr  = clr_we ? clr_addr : wr_addr;
        ram_wdata = clr_we ? '0 : wr_data;
        ram_be    = clr_we ? '1 : wr_be;
    end

    // ------------------------------------------------------------------
    // Storage: byte-lane writes, registered read (old data on collision)
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] ram_rd_q;

    always_ff @(posedge clk) begin
        if (ram_we) begin
            for (int i = 0; i < BE_W; i++) begin
                if (ram_be[i]) begin
                    mem[ram_addr][i*8 +: 8] <= ram_wdata[i*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rd_fire) begin
            ram_rd_q <= mem[rd_addr];
        end
    end

    // ------------------------------------------------------------------
    // Read stage 1: the RAM returns pre-write data; for the new-data mode a
    // colliding write is remembered and merged in after the array read.
    // ------------------------------------------------------------------
    logic              s1_valid_q, s1_valid_d;
    logic              hit_q, hit_d;
    logic [DATA_W-1:0] byp_data_q, byp_data_d;
    logic [BE_W-1:0]   byp_be_q, byp_be_d;
    logic [DATA_W-1:0] s1_word;

    always_comb begin
        s1_valid_d = rd_fire;
        hit_d      = hit_q;
        byp_data_d = byp_data_q;
        byp_be_d   = byp_be_q;
        if (rd_fire) begin
            hit_d      = (RDW_MODE != 0) && usr_we && (wr_addr == rd_addr);
            byp_data_d = wr_data;
            byp_be_d   = wr_be;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            hit_q      <= 1'b0;
            byp_data_q <= '0;
            byp_be_q   <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            hit_q      <= hit_d;
            byp_data_q <= byp_data_d;
            byp_be_q   <= byp_be_d;
        end
    end

    for (genvar gi = 0; gi < BE_W; gi++) begin : g_byp
        assign s1_word[gi*8 +: 8] = be_merge(ram_rd_q[gi*8 +: 8],
                                             byp_data_q[gi*8 +: 8],
                                             hit_q & byp_be_q[gi]);
    end

    // ------------------------------------------------------------------
    // Output stage
    // ------------------------------------------------------------------
    if (OUT_REG != 0) begin : g_out_reg
        logic [DATA_W-1:0] rd_data_q, rd_data_d;
        logic              rd_valid_q, rd_valid_d;

        always_comb begin
            rd_valid_d = s1_valid_q;
            rd_data_d  = s1_valid_q ? s1_word : rd_data_q;
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                rd_data_q  <= '0;
                rd_valid_q <= 1'b0;
            end else begin
                rd_data_q  <= rd_data_d;
                rd_valid_q <= rd_valid_d;
            end
        end

        assign rd_data  = rd_data_q;
        assign rd_valid = rd_valid_q;
    end else begin : g_out_direct
        // The RAM read register is not reset, so the output is forced to
        // zero until the first word has been read after reset.
        logic seen_q, seen_d;

        always_comb begin
            seen_d = seen_q | rd_fire;
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                seen_q <= 1'b0;
            end else begin
                seen_q <= seen_d;
            end
        end

        assign rd_data  = seen_q ? s1_word : '0;
        assign rd_valid = s1_valid_q;
    end

endmodule
